// File: rtl/spw_token_generator.sv
// SpaceWire token transmitter. It serialises NULL, FCT, N-char and time-code
// tokens onto a data-strobe pair, one bit per clock, with odd parity. It also
// keeps the N-char credit that received FCTs grant.
module spw_token_generator #(
  parameter int MAX_CREDIT = 56
) (
  input  logic       posedge_clk,
  input  logic       rx_resetn,
  input  logic       enable,
  input  logic       send_fct,
  input  logic       send_char,
  input  logic [8:0] char_in,
  input  logic       send_time,
  input  logic [7:0] time_in,
  input  logic       credit_fct,
  output logic       ack_fct,
  output logic       ack_char,
  output logic       ack_time,
  output logic       tx_dout,
  output logic       tx_sout,
  output logic [5:0] tx_credit,
  output logic       credit_error
);

  localparam logic [6:0] MAX_C = 7'(MAX_CREDIT);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic        w_load;
  logic        w_shift;
  logic        w_atLast;

  logic [13:0] r_shift;
  logic [3:0]  r_cnt;
  logic [3:0]  r_lastIdx;
  logic        r_prevPar;

  logic        w_selTime;
  logic        w_selFct;
  logic        w_selChar;
  logic        w_charAccept;
  logic [13:0] w_tokBits;
  logic [3:0]  w_tokLastIdx;
  logic        w_tokPar;
  logic        w_nextBit;
  logic        w_moveBit;
  logic [6:0]  w_creditSum;

  // Request arbitration for the next token: time-code, then FCT, then an
  // N-char if credit remains. Anything else falls through to NULL.
  always_comb begin
    w_selTime = send_time;
    w_selFct  = !send_time && send_fct;
    w_selChar = !send_time && !send_fct && send_char && (tx_credit != 6'd0);
  end

  // Build the next token in transmit order, with bit 0 first. r_prevPar holds
  // the XOR of the previous token's payload. So an ESC or control-token parity
  // bit is r_prevPar and a data parity bit is its inverse. The inner FCT of a
  // NULL follows an ESC, whose payload XOR is 0, so its parity bit is always 0.
  // The inner data part of a time-code follows the same ESC, so its parity bit
  // is always 1.
  always_comb begin
    w_tokBits    = '0;
    w_tokLastIdx = 4'd7;
    w_tokPar     = 1'b0;
    if (w_selTime) begin
      w_tokBits    = {time_in, 1'b0, 1'b1, 3'b111, r_prevPar};
      w_tokLastIdx = 4'd13;
      w_tokPar     = ^time_in;
    end else if (w_selFct) begin
      w_tokBits    = {10'd0, 2'b00, 1'b1, r_prevPar};
      w_tokLastIdx = 4'd3;
      w_tokPar     = 1'b0;
    end else if (w_selChar) begin
      if (char_in[8]) begin
        if (char_in[0]) begin
          w_tokBits = {10'd0, 2'b01, 1'b1, r_prevPar};
        end else begin
          w_tokBits = {10'd0, 2'b10, 1'b1, r_prevPar};
        end
        w_tokLastIdx = 4'd3;
        w_tokPar     = 1'b1;
      end else begin
        w_tokBits    = {4'd0, char_in[7:0], 1'b0, ~r_prevPar};
        w_tokLastIdx = 4'd9;
        w_tokPar     = ^char_in[7:0];
      end
    end else begin
      w_tokBits    = {6'd0, 8'b0010_1110} | {13'd0, r_prevPar};
      w_tokLastIdx = 4'd7;
      w_tokPar     = 1'b0;
    end
  end

  // State register for the transmit FSM.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. In SEND the FSM either shifts within the token or, on
  // the last bit, loads the next token. It drops to IDLE if enable is low at
  // that boundary. enable is ignored mid-token.
  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_atLast    = (r_cnt == r_lastIdx);
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_load      = 1'b1;
          w_stateNext = SEND;
        end
      end
      SEND: begin
        if (w_atLast) begin
          if (enable) begin
            w_load = 1'b1;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_shift = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Pick the bit to launch this edge and note which request, if any, is
  // being accepted. EOP and EEP consume credit just like data.
  always_comb begin
    w_moveBit    = w_load || w_shift;
    w_nextBit    = w_load ? w_tokBits[0] : r_shift[0];
    w_charAccept = w_load && w_selChar;
  end

  // Shift register, bit counter, parity history, line drivers and acks. The
  // strobe flips whenever the data line repeats its value, so exactly one of
  // the two lines changes per bit.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_lastIdx <= '0;
      r_prevPar <= 1'b0;
      tx_dout   <= 1'b0;
      tx_sout   <= 1'b0;
      ack_fct   <= 1'b0;
      ack_char  <= 1'b0;
      ack_time  <= 1'b0;
    end else begin
      ack_time <= w_load && w_selTime;
      ack_fct  <= w_load && w_selFct;
      ack_char <= w_charAccept;
      if (w_load) begin
        r_shift   <= {1'b0, w_tokBits[13:1]};
        r_cnt     <= 4'd0;
        r_lastIdx <= w_tokLastIdx;
        r_prevPar <= w_tokPar;
      end else if (w_shift) begin
        r_shift <= {1'b0, r_shift[13:1]};
        r_cnt   <= r_cnt + 4'd1;
      end
      if (w_moveBit) begin
        tx_dout <= w_nextBit;
        tx_sout <= tx_sout ^ (w_nextBit == tx_dout);
      end
    end
  end

  // Net credit change for this edge. A received FCT adds 8 and an accepted
  // N-char takes 1.
  always_comb begin
    w_creditSum = {1'b0, tx_credit};
    if (credit_fct) begin
      w_creditSum = w_creditSum + 7'd8;
    end
    if (w_charAccept) begin
      w_creditSum = w_creditSum - 7'd1;
    end
  end

  // Credit counter with a sticky overflow flag. An FCT that would push the
  // count past the ceiling leaves the count untouched and raises the error.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      tx_credit    <= 6'd0;
      credit_error <= 1'b0;
    end else begin
      if (credit_fct && (w_creditSum > MAX_C)) begin
        credit_error <= 1'b1;
      end else if (credit_fct || w_charAccept) begin
        tx_credit <= w_creditSum[5:0];
      end
    end
  end

endmodule

// File: tb/tb_spw_token_generator.sv
// Directed bench for spw_token_generator. Expected line bits and acks are
// queued as each stimulus step is driven, then popped one per clock.
module tb_spw_token_generator;

  logic       posedge_clk;
  logic       rx_resetn;
  logic       enable;
  logic       send_fct;
  logic       send_char;
  logic [8:0] char_in;
  logic       send_time;
  logic [7:0] time_in;
  logic       credit_fct;
  logic       ack_fct;
  logic       ack_char;
  logic       ack_time;
  logic       tx_dout;
  logic       tx_sout;
  logic [5:0] tx_credit;
  logic       credit_error;

  typedef struct packed {
    logic d;
    logic aC;
    logic aF;
    logic aT;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   expCredit  = 0;
  logic expDout    = 1'b0;
  logic expSout    = 1'b0;

  localparam int ACK_NONE = 0;
  localparam int ACK_CHAR = 1;
  localparam int ACK_FCT  = 2;
  localparam int ACK_TIME = 3;

  localparam string NULL_TOK = "01110100";

  spw_token_generator #(.MAX_CREDIT(56)) dut (
    .posedge_clk (posedge_clk),
    .rx_resetn   (rx_resetn),
    .enable      (enable),
    .send_fct    (send_fct),
    .send_char   (send_char),
    .char_in     (char_in),
    .send_time   (send_time),
    .time_in     (time_in),
    .credit_fct  (credit_fct),
    .ack_fct     (ack_fct),
    .ack_char    (ack_char),
    .ack_time    (ack_time),
    .tx_dout     (tx_dout),
    .tx_sout     (tx_sout),
    .tx_credit   (tx_credit),
    .credit_error(credit_error)
  );

  initial posedge_clk = 1'b0;
  always #5 posedge_clk = ~posedge_clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  // Queue one token; s lists line bits in transmit order, ack marks bit 0.
  task automatic applyStimulus(input string s, input int ackKind);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.d  = (s[i] == "1");
      e.aC = (i == 0) && (ackKind == ACK_CHAR);
      e.aF = (i == 0) && (ackKind == ACK_FCT);
      e.aT = (i == 0) && (ackKind == ACK_TIME);
      q.push_back(e);
    end
  endtask

  task automatic popCheck(input string tag);
    exp_t e;
    @(posedge posedge_clk);
    #1;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s: scoreboard empty, observed dout %0b expected a queued bit", tag, tx_dout);
    end else begin
      e = q.pop_front();
      if (e.d == expDout) expSout = ~expSout;
      expDout = e.d;
      checkOutput(tag, {3'b000, tx_dout, tx_sout, ack_char, ack_fct, ack_time},
                  {3'b000, expDout, expSout, e.aC, e.aF, e.aT});
    end
  endtask

  task automatic drainAll(input string tag);
    while (q.size() > 0) popCheck(tag);
  endtask

  task automatic idleTick(input string tag);
    @(posedge posedge_clk);
    #1;
    checkOutput(tag, {3'b000, tx_dout, tx_sout, ack_char, ack_fct, ack_time},
                {3'b000, expDout, expSout, 3'b000});
  endtask

  task automatic checkCredit(input string tag);
    checkOutput(tag, {2'b00, tx_credit}, 8'(expCredit));
  endtask

  task automatic checkError(input string tag, input logic expErr);
    checkOutput(tag, {7'd0, credit_error}, {7'd0, expErr});
  endtask

  initial begin
    rx_resetn  = 1'b0;
    enable     = 1'b0;
    send_fct   = 1'b0;
    send_char  = 1'b0;
    char_in    = 9'h000;
    send_time  = 1'b0;
    time_in    = 8'h00;
    credit_fct = 1'b0;
    repeat (3) @(posedge posedge_clk);
    #1;
    checkOutput("reset lines/acks", {3'b000, tx_dout, tx_sout, ack_char, ack_fct, ack_time}, 8'h00);
    checkCredit("reset credit");
    checkError("reset error", 1'b0);
    rx_resetn = 1'b1;
    idleTick("idle before enable");
    idleTick("idle before enable");

    // Free-running NULLs right after reset.
    enable = 1'b1;
    repeat (3) applyStimulus(NULL_TOK, ACK_NONE);
    drainAll("null after reset");

    // N-char request with no credit is never accepted.
    send_char = 1'b1;
    char_in   = 9'h041;
    repeat (3) applyStimulus(NULL_TOK, ACK_NONE);
    drainAll("null no credit");
    checkCredit("credit still zero");

    // Credit arrives on a boundary edge and cannot be used there.
    credit_fct = 1'b1;
    applyStimulus(NULL_TOK, ACK_NONE);
    popCheck("null credit boundary");
    credit_fct = 1'b0;
    expCredit  = 8;
    checkCredit("credit after fct");
    drainAll("null credit boundary");

    // Data 0x41 is sent at the next boundary.
    applyStimulus("1010000010", ACK_CHAR);
    popCheck("data 0x41");
    send_char = 1'b0;
    char_in   = 9'h1FF;
    expCredit = 7;
    checkCredit("credit after data");
    drainAll("data 0x41");

    // EOP; its odd payload flips the next ESC parity bit to 1.
    send_char = 1'b1;
    char_in   = 9'h100;
    applyStimulus("0101", ACK_CHAR);
    popCheck("eop");
    send_char = 1'b0;
    expCredit = 6;
    checkCredit("credit after eop");
    drainAll("eop");
    applyStimulus("11110100", ACK_NONE);
    drainAll("null after eop");

    // Time-code beats FCT at the same boundary; the FCT follows.
    send_time = 1'b1;
    time_in   = 8'h3F;
    send_fct  = 1'b1;
    applyStimulus("01111011111100", ACK_TIME);
    popCheck("time 0x3f");
    send_time = 1'b0;
    time_in   = 8'h00;
    drainAll("time 0x3f");
    applyStimulus("0100", ACK_FCT);
    popCheck("fct");
    send_fct = 1'b0;
    drainAll("fct");
    applyStimulus(NULL_TOK, ACK_NONE);
    drainAll("null after fct");

    // Enable falling mid-token lets the token finish, then the lines hold.
    applyStimulus(NULL_TOK, ACK_NONE);
    repeat (3) popCheck("null enable drop");
    enable = 1'b0;
    drainAll("null enable drop");
    repeat (3) idleTick("idle hold");
    enable = 1'b1;
    applyStimulus(NULL_TOK, ACK_NONE);
    drainAll("null re-enable");

    // Credit ceiling and sticky overflow, starting from a clean reset.
    rx_resetn = 1'b0;
    enable    = 1'b0;
    q.delete();
    expDout   = 1'b0;
    expSout   = 1'b0;
    expCredit = 0;
    @(posedge posedge_clk);
    #1;
    rx_resetn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      credit_fct = 1'b1;
      @(posedge posedge_clk);
      #1;
      credit_fct = 1'b0;
      expCredit += 8;
      checkCredit("credit pulse");
    end
    checkError("no overflow at 56", 1'b0);
    credit_fct = 1'b1;
    @(posedge posedge_clk);
    #1;
    credit_fct = 1'b0;
    checkCredit("credit held at 56");
    checkError("overflow sticky", 1'b1);
    idleTick("idle during credit");

    // Reset asserted at bit 5 of a data char.
    enable = 1'b1;
    applyStimulus(NULL_TOK, ACK_NONE);
    drainAll("null before data");
    send_char = 1'b1;
    char_in   = 9'h0A5;
    applyStimulus("1010100101", ACK_CHAR);
    popCheck("data 0xa5");
    send_char = 1'b0;
    expCredit = 55;
    checkCredit("credit 56 to 55");
    repeat (5) popCheck("data 0xa5");
    #1;
    rx_resetn = 1'b0;
    #1;
    q.delete();
    expDout   = 1'b0;
    expSout   = 1'b0;
    expCredit = 0;
    checkOutput("async reset lines", {3'b000, tx_dout, tx_sout, ack_char, ack_fct, ack_time}, 8'h00);
    checkCredit("async reset credit");
    checkError("async reset error", 1'b0);
    @(posedge posedge_clk);
    #1;
    rx_resetn = 1'b1;
    repeat (2) applyStimulus(NULL_TOK, ACK_NONE);
    drainAll("null after mid reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spw_token_generator.md
# spw_token_generator

Debug-side SpaceWire token transmitter: serialises NULL, FCT, N-char (data, EOP, EEP) and time-code tokens onto a data-strobe pair with ECSS-E-ST-50-12C odd parity, one bit per clock. It is the transmit counterpart of the token detector in the DEBUG_VERILOG set. It drives a known-good token stream into that detector, or into a link under test, and applies flow-control credit from received FCTs.

## Interface
Parameters:
- MAX_CREDIT, 56: credit ceiling in N-chars (7 FCTs × 8).

Ports:
- posedge_clk  in  1  bit clock, one transmitted bit per rising edge
- rx_resetn  in  1  reset, asynchronous, active-low; clock posedge_clk
- enable  in  1  transmit enable, sampled at token boundaries only
- send_fct  in  1  FCT request, level, held until ack_fct
- send_char  in  1  N-char request, level, held until ack_char
- char_in  in  9  N-char; bit8=0 data char_in[7:0]; bit8=1 control: char_in[0]=0 EOP, char_in[0]=1 EEP
- send_time  in  1  time-code request, level, held until ack_time
- time_in  in  8  time-code value
- credit_fct  in  1  one-cycle pulse: one FCT received, adds 8 credits
- ack_fct, ack_char, ack_time  out  1  one-cycle pulse: request accepted, first bit launched
- tx_dout  out  1  data line
- tx_sout  out  1  strobe line
- tx_credit  out  6  current N-char credit
- credit_error  out  1  sticky credit overflow flag

## Operation
- Bit order is transmit order, LSB of payload first.
  - FCT = P,1,0,0.
  - EOP = P,1,0,1.
  - EEP = P,1,1,0.
  - ESC = P,1,1,1.
  - NULL = ESC + FCT, 8 bits.
  - Data = P,0,d0..d7.
  - Time-code = ESC + P,0,t0..t7, 14 bits.
- Parity P = NOT(XOR of previous token's payload bits XOR current flag bit).
  - Control payload is 2 bits; data/time payload is 8 bits.
  - After reset the previous payload is 0.
  - Within NULL and time-code, the inner ESC is the previous token for the second part.
- Token selection happens at each boundary, in the same cycle the last bit of the current token is launched, so the stream has no gaps.
  - Priority: time-code > FCT > N-char (only if tx_credit>0) > NULL.
- Data-strobe encoding:
  - tx_dout = bit.
  - tx_sout toggles exactly when tx_dout does not change.
  - So tx_dout^tx_sout toggles every bit.
- FSM states:
  - IDLE: outputs hold; go to SEND when enable=1.
  - SEND: shift register plus bit counter 0..len-1; at the last bit, return to IDLE if enable=0, otherwise load the next token.
- Credit:
  - Accepting an N-char decrements tx_credit by 1.
  - credit_fct adds 8.
  - If the sum would exceed MAX_CREDIT, tx_credit is unchanged and credit_error is set.
  - Simultaneous credit_fct and N-char accept: net +7, checked against MAX_CREDIT.
- credit_error clears only on reset.
- enable falling mid-token does not truncate the token.
- Reset values: tx_dout=0, tx_sout=0, all acks=0, tx_credit=0, credit_error=0, state IDLE, previous-payload parity=0.
- Reset mid-token: outputs are 0 immediately (asynchronous); the next stream restarts with NULL parity as after power-up.

## Timing
- In IDLE, enable=1 sampled at edge n: bit 0 is on tx_dout/tx_sout after edge n.
- Ack for a request sampled at boundary edge n is high for exactly the cycle after edge n.
- A request must be stable before the boundary edge.
- char_in and time_in are captured at that edge and may change after ack.
- A 4-bit token occupies 4 edges, NULL 8, data 10, time-code 14.
- Next token's bit 0 appears at the edge following the previous token's last bit.
- credit_fct takes effect on tx_credit one edge after the pulse.
- A credit arriving on a boundary edge is not usable at that boundary.

## Test plan
- Reset, enable=1, no requests: tx_dout = 0,1,1,1,0,1,0,0 repeating; tx_dout^tx_sout toggles every bit; no acks.
- One credit_fct, then send_char with char_in=0x041: after the current NULL, ack_char pulses, tx_dout = 1,0,1,0,0,0,0,0,1,0, tx_credit goes 8→7.
- send_char with tx_credit=0: never acked; NULLs continue indefinitely.
- send_time (time_in=0x3F) and send_fct at the same boundary after a NULL: ack_time first, with stream 0,1,1,1,1,0,1,1,1,1,1,1,0,0; then ack_fct with stream 0,1,0,0.
- 7 credit_fct pulses: tx_credit=56, credit_error=0; 8th pulse: tx_credit stays 56, credit_error=1.
- Assert rx_resetn=0 at bit 5 of a data char: tx_dout=tx_sout=0 immediately, tx_credit=0; after release with enable=1, stream restarts 0,1,1,1,0,1,0,0.
